// File: rtl/day10_solver_scheduler.sv
// day10_solver_scheduler
// Shares NUM_LANES solver lanes among a stream of parsed day-10 machines.
// Jobs go to free lanes picked round-robin from a dispatch pointer. One lane
// result is collected per cycle, picked round-robin from a collect pointer,
// and added to a wrapping batch accumulator. After the last job of the batch
// has drained, the total is handed to the output writer.
// Optional feature macro: DAY10_SCHED_PERF_EN adds the perf_jobs and
// perf_cycles counters and their output ports.
`timescale 1ns/1ps

module day10_solver_scheduler #(
  parameter int  NUM_LANES    = 4,
  parameter int  RESULT_WIDTH = 16,
  parameter int  SUM_WIDTH    = 32,
  localparam int LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              job_valid,
  input  logic                              job_last,
  output logic                              job_ready,
  output logic [LANE_W-1:0]                 job_lane,
  output logic [NUM_LANES-1:0]              lane_start,
  input  logic [NUM_LANES-1:0]              lane_done,
  input  logic [NUM_LANES*RESULT_WIDTH-1:0] lane_result,
  output logic [NUM_LANES-1:0]              lane_ack,
  output logic                              sum_valid,
  output logic [SUM_WIDTH-1:0]              sum_data,
  input  logic                              sum_ready,
  output logic                              sum_overflow
`ifdef DAY10_SCHED_PERF_EN
  ,
  output logic [15:0]                       perf_jobs,
  output logic [31:0]                       perf_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUTPUT} state_t;

  state_t                  state, state_next;
  logic [NUM_LANES-1:0]    busy;
  logic [NUM_LANES-1:0]    start_set;
  logic [LANE_W-1:0]       disp_ptr;
  logic [LANE_W-1:0]       coll_ptr;
  logic [LANE_W-1:0]       grant;
  logic                    free_found;
  logic                    grant_found;
  logic                    accept;
  logic [RESULT_WIDTH-1:0] grant_result;
  logic [SUM_WIDTH-1:0]    sum;
  logic [SUM_WIDTH:0]      sum_add;
  logic                    overflow;
  logic                    last_seen;

  // First set bit of req at or after ptr, wrapping; returns {found, index}.
  function automatic logic [LANE_W:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                               input logic [LANE_W-1:0]    ptr);
    logic              found;
    logic [LANE_W-1:0] sel;
    int                k;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_LANES) k = k - NUM_LANES;
      if (!found && req[k[LANE_W-1:0]]) begin
        found = 1'b1;
        sel   = k[LANE_W-1:0];
      end
    end
    return {found, sel};
  endfunction

  // Pointer advance modulo NUM_LANES (works for non-power-of-two lane counts).
  function automatic logic [LANE_W-1:0] ptr_inc(input logic [LANE_W-1:0] p);
    return (p == LANE_W'(NUM_LANES - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NUM_LANES-1:0] onehot(input logic [LANE_W-1:0] idx);
    logic [NUM_LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin selection of the dispatch lane and the collection grant.
  always_comb begin
    {free_found, job_lane}  = rr_pick(~busy, disp_ptr);
    {grant_found, grant}    = rr_pick(lane_done & busy, coll_ptr);
  end

  assign job_ready    = (state == RUN) && free_found;
  assign accept       = job_valid && job_ready;
  assign start_set    = accept ? onehot(job_lane) : '0;
  assign lane_ack     = grant_found ? onehot(grant) : '0;
  assign grant_result = lane_result[int'(grant)*RESULT_WIDTH +: RESULT_WIDTH];
  assign sum_add      = {1'b0, sum} +
                        {{(SUM_WIDTH + 1 - RESULT_WIDTH){1'b0}}, grant_result};

  assign sum_valid    = (state == OUTPUT);
  assign sum_data     = sum_valid ? sum : '0;
  assign sum_overflow = overflow;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Batch sequencing: open, close on the last job, drain, hand off the total.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (accept && job_last) state_next = DRAIN;
      DRAIN:   if (last_seen && (busy == '0) && !grant_found) state_next = OUTPUT;
      OUTPUT:  if (sum_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane bookkeeping, pointers and the batch accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      lane_start <= '0;
      disp_ptr   <= '0;
      coll_ptr   <= '0;
      sum        <= '0;
      overflow   <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      lane_start <= start_set;
      // A set and a clear never hit the same lane: dispatch only picks idle
      // lanes and collection only grants busy ones.
      busy       <= (busy | start_set) & ~lane_ack;
      if (accept)      disp_ptr <= ptr_inc(job_lane);
      if (grant_found) coll_ptr <= ptr_inc(grant);

      if (state == IDLE) begin
        sum       <= '0;
        overflow  <= 1'b0;
        last_seen <= 1'b0;
      end else begin
        if (grant_found) begin
          sum <= sum_add[SUM_WIDTH-1:0];
          if (sum_add[SUM_WIDTH]) overflow <= 1'b1;
        end
        if (accept && job_last) last_seen <= 1'b1;
      end
    end
  end

`ifdef DAY10_SCHED_PERF_EN
  // Saturating batch counters: cleared in IDLE, frozen while the total waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs   <= '0;
      perf_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          perf_jobs   <= '0;
          perf_cycles <= '0;
        end
        RUN, DRAIN: begin
          if (accept && (perf_jobs != '1)) perf_jobs <= perf_jobs + 1'b1;
          if (perf_cycles != '1)           perf_cycles <= perf_cycles + 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
